// File: rtl/uart_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_loader_pkg
// Shared definitions for the UART instruction-memory loader:
//   SYNC_BYTE     - first byte of every load frame
//   rx_state_t    - serial receiver states
//   ld_state_t    - frame/loader states
//   clks_per_bit  - clock cycles per serial bit (integer division)
// -----------------------------------------------------------------------------
package uart_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        L_IDLE,
        L_LEN_HI,
        L_LEN_LO,
        L_DATA,
        L_CSUM,
        L_DONE,
        L_ERR
    } ld_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// 8N1 LSB-first UART receiver with a 2-flop input synchronizer.
//
// Ports:
//   CLK         in   system clock
//   rstn        in   asynchronous active-low reset
//   uart_rx     in   asynchronous serial line, idle high
//   rx_byte     out  received byte, valid while byte_valid is high
//   byte_valid  out  one-cycle pulse: a byte with a good stop bit arrived
//   frame_err   out  one-cycle pulse: stop bit sampled low, byte discarded
//
// Handshake: byte_valid is a valid-only strobe with no ready; the consumer
// must take rx_byte in the cycle byte_valid is high.
// -----------------------------------------------------------------------------
module uart_rx_core
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       rstn,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    logic            rx_meta;
    logic            rx_s;
    rx_state_t       rx_state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;

    // Synchronizer resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            rx_state   <= R_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) rx_state <= R_START;
                end
                // Re-check the start bit at its centre; a short low is a glitch.
                R_START: begin
                    if (cnt == HALF_M1) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // Sampling point is now mid-bit; step a full bit per sample.
                R_DATA: begin
                    if (cnt == BIT_M1) begin
                        cnt     <= '0;
                        rx_byte <= {rx_s, rx_byte[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rx_state <= R_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                R_STOP: begin
                    if (cnt == BIT_M1) begin
                        cnt        <= '0;
                        byte_valid <= rx_s;
                        frame_err  <= !rx_s;
                        rx_state   <= R_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_imem_loader.sv
// -----------------------------------------------------------------------------
// uart_imem_loader
// Receives a framed program image over UART and writes it into instruction
// memory, holding the CPU in reset while a load is in progress.
// Frame: A5, LEN_HI, LEN_LO, 4*LEN data bytes (big-endian words), CSUM,
// where CSUM is the XOR of all data bytes.
//
// Ports:
//   CLK         in   system clock
//   rstn        in   asynchronous active-low reset
//   uart_rx     in   serial input, idle high, 8N1
//   imem_we     out  one-cycle IMem write strobe
//   imem_addr   out  IMem word address of the write
//   imem_wdata  out  IMem write data
//   cpu_hold    out  1 = keep the CPU in reset
//   load_done   out  last load finished with a good checksum
//   load_err    out  last load aborted (bad length, framing or checksum)
//   word_cnt    out  words written in the current or last load
// -----------------------------------------------------------------------------
module uart_imem_loader
    import uart_loader_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  rstn,
    input  logic                  uart_rx,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [15:0]           word_cnt
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    // Largest image that fits in IMem; 17 bits so 2^16 is representable.
    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;

    logic [7:0]            rx_byte;
    logic                  byte_valid;
    logic                  frame_err;

    ld_state_t             ld_state;
    logic [7:0]            len_hi;
    logic [15:0]           rem;
    logic [23:0]           word_sh;
    logic [1:0]            byte_idx;
    logic [7:0]            xor_acc;
    logic [ADDR_WIDTH-1:0] addr;

    logic [15:0]           len_rx;
    logic                  in_session;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .CLK       (CLK),
        .rstn      (rstn),
        .uart_rx   (uart_rx),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    assign len_rx     = {len_hi, rx_byte};
    assign in_session = !(ld_state inside {L_IDLE, L_DONE, L_ERR});

    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            ld_state   <= L_IDLE;
            len_hi     <= '0;
            rem        <= '0;
            word_sh    <= '0;
            byte_idx   <= '0;
            xor_acc    <= '0;
            addr       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_cnt   <= '0;
        end else begin
            imem_we <= 1'b0;
            if (frame_err && in_session) begin
                ld_state <= L_ERR;
                load_err <= 1'b1;
            end else if (byte_valid) begin
                case (ld_state)
                    // Only a sync byte opens a session; anything else is line noise.
                    L_IDLE, L_DONE, L_ERR: begin
                        if (rx_byte == SYNC_BYTE) begin
                            ld_state  <= L_LEN_HI;
                            cpu_hold  <= 1'b1;
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                            addr      <= '0;
                            word_cnt  <= '0;
                            xor_acc   <= '0;
                            byte_idx  <= '0;
                        end
                    end
                    L_LEN_HI: begin
                        len_hi   <= rx_byte;
                        ld_state <= L_LEN_LO;
                    end
                    L_LEN_LO: begin
                        if (len_rx == 16'd0) begin
                            ld_state <= L_CSUM;
                        end else if ({1'b0, len_rx} > MAX_LEN) begin
                            ld_state <= L_ERR;
                            load_err <= 1'b1;
                        end else begin
                            rem      <= len_rx;
                            ld_state <= L_DATA;
                        end
                    end
                    L_DATA: begin
                        word_sh  <= {word_sh[15:0], rx_byte};
                        xor_acc  <= xor_acc ^ rx_byte;
                        byte_idx <= byte_idx + 2'd1;
                        // Fourth byte completes the word; strobe it out next cycle.
                        if (byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= addr;
                            imem_wdata <= {word_sh, rx_byte};
                            addr       <= addr + ADDR_WIDTH'(1);
                            word_cnt   <= word_cnt + 16'd1;
                            rem        <= rem - 16'd1;
                            if (rem == 16'd1) ld_state <= L_CSUM;
                        end
                    end
                    L_CSUM: begin
                        if (rx_byte == xor_acc) begin
                            ld_state  <= L_DONE;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            ld_state <= L_ERR;
                            load_err <= 1'b1;
                        end
                    end
                    default: ld_state <= L_IDLE;
                endcase
            end
        end
    end

endmodule
